// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and decode-stage update bus of the branch predictor.
// master = pipeline side driving lookups/updates, slave = predictor.
interface branch_predictor_if;
    logic [15:0] PC_curr;
    logic [15:0] IF_ID_PC_curr;
    logic        wen_BHT;
    logic        wen_BTB;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        prediction;
    logic [15:0] predicted_target;

    modport master (
        output PC_curr, IF_ID_PC_curr, wen_BHT, wen_BTB, actual_taken, actual_target,
        input  prediction, predicted_target
    );

    modport slave (
        input  PC_curr, IF_ID_PC_curr, wen_BHT, wen_BTB, actual_taken, actual_target,
        output prediction, predicted_target
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: 16-entry direct-mapped BHT/BTB with 2-bit saturating counters.
// Optional BRANCH_PREDICTOR_TAG_EN adds an 11-bit PC[15:5] tag per entry to stop aliasing.
module branch_predictor (
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bp
);
    logic [1:0]  counter [16];
    logic [15:0] target  [16];
    logic        valid   [16];
    logic [3:0]  rd_idx;
    logic [3:0]  wr_idx;
    logic        hit;
    logic [1:0]  cur_cnt;
    logic [1:0]  nxt_cnt;

    assign rd_idx = bp.PC_curr[4:1];
    assign wr_idx = bp.IF_ID_PC_curr[4:1];

`ifdef BRANCH_PREDICTOR_TAG_EN
    logic [10:0] tag [16];
    logic        unused_bits;
    assign unused_bits = bp.PC_curr[0] ^ bp.IF_ID_PC_curr[0];
    assign hit = tag[rd_idx] == bp.PC_curr[15:5];
`else
    logic unused_bits;
    assign unused_bits = ^{bp.PC_curr[15:5], bp.PC_curr[0], bp.IF_ID_PC_curr[15:5], bp.IF_ID_PC_curr[0]};
    assign hit = 1'b1;
`endif

    // Lookup reads pre-edge array contents, so a same-cycle update is never bypassed.
    always_comb begin
        bp.prediction       = valid[rd_idx] & hit & counter[rd_idx][1];
        bp.predicted_target = (valid[rd_idx] & hit) ? target[rd_idx] : 16'h0000;
    end

    always_comb begin
        cur_cnt = counter[wr_idx];
        nxt_cnt = bp.actual_taken ? ((cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'b01)
                                  : ((cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'b01);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                counter[i] <= 2'b01;
                target[i]  <= 16'h0000;
                valid[i]   <= 1'b0;
`ifdef BRANCH_PREDICTOR_TAG_EN
                tag[i]     <= 11'h000;
`endif
            end
        end else begin
            if (bp.wen_BHT)
                counter[wr_idx] <= nxt_cnt;
            if (bp.wen_BTB) begin
                target[wr_idx] <= bp.actual_target;
                valid[wr_idx]  <= 1'b1;
`ifdef BRANCH_PREDICTOR_TAG_EN
                tag[wr_idx]    <= bp.IF_ID_PC_curr[15:5];
`endif
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, counter training, no-bypass timing,
// aliasing/tagging and reset priority for branch_predictor.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    branch_predictor_if bp ();

    branch_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic pred_exp, input logic [15:0] tgt_exp);
        #1;
        compared++;
        assert (bp.prediction === pred_exp) else begin
            mismatched++;
            $error("FAIL %s prediction got %b want %b", tag, bp.prediction, pred_exp);
        end
        compared++;
        assert (bp.predicted_target === tgt_exp) else begin
            mismatched++;
            $error("FAIL %s predicted_target got %h want %h", tag, bp.predicted_target, tgt_exp);
        end
    endtask

    task automatic update(input logic [15:0] pc, input logic bht, input logic btb,
                          input logic taken, input logic [15:0] tgt);
        bp.IF_ID_PC_curr = pc;
        bp.wen_BHT       = bht;
        bp.wen_BTB       = btb;
        bp.actual_taken  = taken;
        bp.actual_target = tgt;
        step();
        bp.wen_BHT = 1'b0;
        bp.wen_BTB = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bp.PC_curr       = 16'h0000;
        bp.IF_ID_PC_curr = 16'h0000;
        bp.wen_BHT       = 1'b0;
        bp.wen_BTB       = 1'b0;
        bp.actual_taken  = 1'b0;
        bp.actual_target = 16'h0000;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bp.PC_curr = 16'(2 * i);
            check($sformatf("reset_pc%0h", 2 * i), 1'b0, 16'h0000);
        end

        // train 0x0004: counter 01 -> 10, target 0x0040
        update(16'h0004, 1'b1, 1'b1, 1'b1, 16'h0040);
        bp.PC_curr = 16'h0004;
        check("train_first", 1'b1, 16'h0040);
        bp.PC_curr = 16'h0005;
        check("pc0_ignored", 1'b1, 16'h0040);
        bp.PC_curr = 16'h0006;
        check("neighbour_untouched", 1'b0, 16'h0000);

        for (int i = 0; i < 4; i++) update(16'h0004, 1'b1, 1'b0, 1'b1, 16'h0000);
        bp.PC_curr = 16'h0004;
        check("sat_strong_t", 1'b1, 16'h0040);
        update(16'h0004, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("nt_once_weak_t", 1'b1, 16'h0040);
        update(16'h0004, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("nt_twice_weak_nt", 1'b0, 16'h0040);
        update(16'h0004, 1'b1, 1'b0, 1'b0, 16'h0000);
        update(16'h0004, 1'b1, 1'b0, 1'b0, 16'h0000);
        update(16'h0004, 1'b1, 1'b0, 1'b1, 16'h0000);
        check("sat_strong_nt_then_t", 1'b0, 16'h0040);

        // same-cycle update and lookup of 0x0008: old value now, new value next cycle
        bp.PC_curr       = 16'h0008;
        bp.IF_ID_PC_curr = 16'h0008;
        bp.wen_BHT       = 1'b1;
        bp.wen_BTB       = 1'b1;
        bp.actual_taken  = 1'b1;
        bp.actual_target = 16'h0080;
        check("no_bypass_old", 1'b0, 16'h0000);
        step();
        bp.wen_BHT = 1'b0;
        bp.wen_BTB = 1'b0;
        check("no_bypass_new", 1'b1, 16'h0080);

        // 0x0004 now at 01; one taken update with target -> 10
        update(16'h0004, 1'b1, 1'b1, 1'b1, 16'h0040);
        bp.PC_curr = 16'h0024;
`ifdef BRANCH_PREDICTOR_TAG_EN
        check("alias_0024", 1'b0, 16'h0000);
`else
        check("alias_0024", 1'b1, 16'h0040);
`endif

        // BHT training on an invalid entry counts but cannot predict
        update(16'h000A, 1'b1, 1'b0, 1'b1, 16'h0000);
        update(16'h000A, 1'b1, 1'b0, 1'b1, 16'h0000);
        bp.PC_curr = 16'h000A;
        check("invalid_bht_only", 1'b0, 16'h0000);
        update(16'h000A, 1'b0, 1'b1, 1'b0, 16'h1234);
        check("validated_strong_t", 1'b1, 16'h1234);

        // reset wins over a simultaneous BTB write
        rst_n = 1'b0;
        update(16'h0002, 1'b1, 1'b1, 1'b1, 16'hBEEF);
        rst_n = 1'b1;
        bp.PC_curr = 16'h0002;
        check("reset_priority", 1'b0, 16'h0000);
        bp.PC_curr = 16'h0004;
        check("reset_clears_0004", 1'b0, 16'h0000);
        bp.PC_curr = 16'h000A;
        check("reset_clears_000a", 1'b0, 16'h0000);
        update(16'h000A, 1'b0, 1'b1, 1'b0, 16'h0055);
        check("reset_counter_weak_nt", 1'b0, 16'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset: rst_n, synchronous, active-low.
REQ-003 SHALL have port PC_curr  input  16  fetch-stage PC being looked up.
REQ-004 SHALL have port IF_ID_PC_curr  input  16  PC of the branch resolved in decode; selects the update entry.
REQ-005 SHALL have port wen_BHT  input  1  update the 2-bit counter of the entry selected by IF_ID_PC_curr.
REQ-006 SHALL have port wen_BTB  input  1  write the target of the entry selected by IF_ID_PC_curr.
REQ-007 SHALL have port actual_taken  input  1  resolved branch direction.
REQ-008 SHALL have port actual_target  input  16  resolved branch target.
REQ-009 SHALL have port prediction  output  1  predict taken for PC_curr.
REQ-010 SHALL have port predicted_target  output  16  predicted target for PC_curr.

Function
REQ-011 SHALL hold 16 entries indexed by PC[4:1]; each entry holds a 2-bit counter, a 16-bit target and a valid bit.
REQ-012 SHALL compute the lookup combinationally from PC_curr: prediction = valid & hit & counter[1].
REQ-013 SHALL drive predicted_target = the stored target when valid & hit, else 16'h0000.
REQ-014 SHALL apply all updates on the rising clk edge only; a lookup of the index being updated in the same cycle returns the pre-update contents (no bypass).
REQ-015 SHALL, on wen_BHT, increment the counter when actual_taken=1 and decrement it when actual_taken=0.
REQ-016 SHALL saturate the counter: 2'b11 stays 2'b11 on taken, 2'b00 stays 2'b00 on not-taken.
REQ-017 SHALL assign counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 SHALL, on wen_BTB, write actual_target into the target field and set the valid bit.
REQ-019 SHALL allow wen_BHT and wen_BTB in the same cycle to the same entry, with both updates taking effect.
REQ-020 SHALL leave entries other than the selected index unchanged on every update.
REQ-021 SHALL treat a wen_BHT to an invalid entry as a normal counter update; the valid bit remains 0 and prediction stays 0.
REQ-022 SHALL ignore PC[0] for both indexing and tagging.
REQ-023 SHALL perform updates independently of any pipeline stall; the block has no stall or flush input.

Reset
REQ-024 SHALL, when rst_n=0 at a rising edge, set every counter to 2'b01, every target to 16'h0000 and every valid bit to 0.
REQ-025 SHALL give reset priority over wen_BHT and wen_BTB in the same cycle.
REQ-026 SHALL output prediction=0 and predicted_target=16'h0000 for every PC from the first edge after reset.

Configuration
REQ-027 SHALL, when BRANCH_PREDICTOR_TAG_EN is defined, store PC[15:5] as an 11-bit tag per entry, written on wen_BTB and cleared on reset.
REQ-028 SHALL, with BRANCH_PREDICTOR_TAG_EN, define hit = (stored tag == PC_curr[15:5]).
REQ-029 SHALL, without BRANCH_PREDICTOR_TAG_EN, store no tag and define hit = 1, so entries with the same index alias.

Verification
REQ-030 SHALL cover reset followed by lookups of PC 0x0000..0x001E -> prediction=0 and predicted_target=0x0000 for all of them.
REQ-031 SHALL cover, with IF_ID_PC_curr=0x0004, wen_BTB=1, actual_target=0x0040 and wen_BHT=1, actual_taken=1 in one cycle, then PC_curr=0x0004 -> prediction=1 (counter 10), predicted_target=0x0040.
REQ-032 SHALL cover four consecutive taken updates to 0x0004 followed by one not-taken update -> counter 11 then 10, prediction stays 1; a second not-taken update -> counter 01, prediction=0.
REQ-033 SHALL cover an update and a lookup of 0x0008 in the same cycle -> old value on the lookup that cycle, new value on the cycle after.
REQ-034 SHALL cover training 0x0004 taken with target 0x0040, then looking up 0x0024 -> with the tag macro defined, prediction=0 and target=0x0000; without it, prediction=1 and target=0x0040.
REQ-035 SHALL cover rst_n=0 asserted in the same cycle as wen_BTB=1 to 0x0002 -> entry remains invalid and prediction=0.
